// File: rtl/lzd_pipe.sv
// Pipelined leading-zero / redundant-sign-bit detector with normalising shift.
// The count is resolved combinationally at the input; the barrel shift is spread across the stages.
module lzd_pipe #(
  parameter int W           = 29,
  parameter int SHIFT_WIDTH = $clog2(W),
  parameter int STAGES      = 2,
  parameter int TAG_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_data,
  input  logic                   in_mode,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SHIFT_WIDTH:0]   out_shift,
  output logic [W-1:0]           out_norm,
  output logic                   out_zero,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int LAST = STAGES - 1;

  logic [SHIFT_WIDTH-1:0] cnt;
  logic                   is_zero;
  logic [W-2:0]           sign_diff;
  logic                   accept;

  logic [STAGES-1:0]      st_valid;
  logic [W-1:0]           st_norm [STAGES];
  logic [SHIFT_WIDTH-1:0] st_amt  [STAGES];
  logic                   st_zero [STAGES];
  logic [TAG_W-1:0]       st_tag  [STAGES];

  logic [STAGES-1:0]      src_valid;
  logic [W-1:0]           src_norm [STAGES];
  logic [SHIFT_WIDTH-1:0] src_amt  [STAGES];
  logic                   src_zero [STAGES];
  logic [TAG_W-1:0]       src_tag  [STAGES];

  logic [STAGES-1:0]      move;
  logic                   chain;

  // Shift step j (by 2**j) belongs to exactly one stage, spreading steps evenly.
  function automatic logic [W-1:0] stage_shift(input logic [W-1:0] d,
                                               input logic [SHIFT_WIDTH-1:0] amt,
                                               input int s);
    logic [W-1:0] r;
    r = d;
    for (int j = 0; j < SHIFT_WIDTH; j++) begin
      if (((j * STAGES) / SHIFT_WIDTH) == s && amt[j]) r = r << (1 << j);
    end
    return r;
  endfunction

  always_comb begin
    is_zero   = (in_data == '0);
    sign_diff = '0;
    cnt       = '0;
    if (in_mode) begin
      for (int i = 0; i < W - 1; i++) sign_diff[i] = in_data[i] ^ in_data[W-1];
      cnt = SHIFT_WIDTH'(W - 1);
      for (int i = 0; i < W - 1; i++) begin
        if (sign_diff[i]) cnt = SHIFT_WIDTH'(W - 2 - i);
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (in_data[i]) cnt = SHIFT_WIDTH'(W - 1 - i);
      end
    end
    if (is_zero) cnt = '0;
  end

  // A stage moves when its successor is empty or itself moving; walk from the output back.
  always_comb begin
    move  = '0;
    chain = out_ready;
    for (int s = LAST; s >= 0; s--) begin
      move[s] = chain;
      chain   = chain | ~st_valid[s];
    end
  end

  assign in_ready = ~rst & (~st_valid[0] | move[0]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    src_valid[0] = accept;
    src_norm[0]  = in_data;
    src_amt[0]   = cnt;
    src_zero[0]  = is_zero;
    src_tag[0]   = in_tag;
    for (int s = 1; s < STAGES; s++) begin
      src_valid[s] = st_valid[s-1];
      src_norm[s]  = st_norm[s-1];
      src_amt[s]   = st_amt[s-1];
      src_zero[s]  = st_zero[s-1];
      src_tag[s]   = st_tag[s-1];
    end
  end

  // Payload only loads with a valid operand, so outputs keep the last result across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid <= '0;
      for (int s = 0; s < STAGES; s++) begin
        st_norm[s] <= '0;
        st_amt[s]  <= '0;
        st_zero[s] <= 1'b0;
        st_tag[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (~st_valid[s] | move[s]) begin
          st_valid[s] <= src_valid[s];
          if (src_valid[s]) begin
            st_norm[s] <= stage_shift(src_norm[s], src_amt[s], s);
            st_amt[s]  <= src_amt[s];
            st_zero[s] <= src_zero[s];
            st_tag[s]  <= src_tag[s];
          end
        end
      end
    end
  end

  assign out_valid = st_valid[LAST];
  assign out_shift = {st_zero[LAST], st_amt[LAST]};
  assign out_norm  = st_norm[LAST];
  assign out_zero  = st_zero[LAST];
  assign out_tag   = st_tag[LAST];

endmodule
